// File: rtl/mem_lsu_stage.sv
// MEM stage for the MIPS pipeline: performs loads and stores on a req/ack bus,
// steers byte lanes and checks alignment, then registers write-back fields to WB.
module mem_lsu_stage #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [3:0]            mem_op_i,
  input  logic [31:0]           result_i,
  input  logic [31:0]           store_data_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic                  we_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_sel_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  valid_o,
  output logic [31:0]           result_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic                  we_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o,
  output logic                  align_err_o,
  output logic                  bus_err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SW  = 4'd11;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;

  logic                  is_load, is_store, is_mem, is_half, is_word, misalign;
  logic                  accept, align_fault, ack_done, to_done;
  logic [3:0]            sel_nxt;
  logic [31:0]           wdata_nxt;
  logic [CNT_W-1:0]      cnt_p1;
  logic [3:0]            op_p1;
  logic [1:0]            off_p1;
  logic [REG_ADDR_W-1:0] waddr_p1;
  logic                  we_p1;
  logic [31:0]           hi_p1;
  logic [31:0]           lo_p1;
  logic                  whilo_p1;

  // Big-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [3:0] op,
                                              input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    logic [7:0]  b;
    logic [15:0] h;
    b_sh = rdata >> {~off, 3'b000};
    h_sh = rdata >> {~off[1], 4'b0000};
    b    = b_sh[7:0];
    h    = h_sh[15:0];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'd0, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'd0, h};
      default: load_extend = rdata;
    endcase
  endfunction

  function automatic logic is_load_op(input logic [3:0] op);
    is_load_op = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
                 (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Decode and lane steering for the instruction presented by EX
  always_comb begin
    is_load   = is_load_op(mem_op_i);
    is_store  = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
    is_mem    = is_load || is_store;
    is_half   = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    is_word   = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    misalign  = (is_half && result_i[0]) || (is_word && (result_i[1:0] != 2'b00));
    sel_nxt   = 4'b1000 >> result_i[1:0];
    wdata_nxt = {4{store_data_i[7:0]}};
    if (is_half) begin
      sel_nxt   = 4'b1100 >> result_i[1:0];
      wdata_nxt = {2{store_data_i[15:0]}};
    end else if (is_word) begin
      sel_nxt   = 4'b1111;
      wdata_nxt = store_data_i;
    end
  end

  always_comb begin
    state_nxt   = state;
    stall_o     = 1'b0;
    accept      = 1'b0;
    align_fault = 1'b0;
    ack_done    = 1'b0;
    to_done     = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && is_mem) begin
          if (misalign) begin
            align_fault = 1'b1;
          end else begin
            accept    = 1'b1;
            stall_o   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_p1 == CNT_LAST) begin
          to_done   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // p1: transfer context held for the duration of WAIT
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt_p1   <= '0;
      op_p1    <= mem_op_i;
      off_p1   <= result_i[1:0];
      waddr_p1 <= waddr_i;
      we_p1    <= we_i;
      hi_p1    <= hi_i;
      lo_p1    <= lo_i;
      whilo_p1 <= whilo_i;
    end else if (state == WAIT) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // Bus request and WB output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_sel_o   <= 4'b0000;
      mem_wdata_o <= 32'd0;
      valid_o     <= 1'b0;
      result_o    <= 32'd0;
      waddr_o     <= '0;
      we_o        <= 1'b0;
      hi_o        <= 32'd0;
      lo_o        <= 32'd0;
      whilo_o     <= 1'b0;
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      we_o        <= 1'b0;
      whilo_o     <= 1'b0;
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
      if (accept) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= is_store;
        mem_addr_o  <= {result_i[ADDR_W-1:2], 2'b00};
        mem_sel_o   <= sel_nxt;
        mem_wdata_o <= wdata_nxt;
      end else if (ack_done || to_done) begin
        mem_req_o <= 1'b0;
      end
      if (state == IDLE && valid_i && !accept) begin
        valid_o     <= 1'b1;
        result_o    <= result_i;
        waddr_o     <= waddr_i;
        hi_o        <= hi_i;
        lo_o        <= lo_i;
        we_o        <= we_i && !align_fault;
        whilo_o     <= whilo_i && !align_fault;
        align_err_o <= align_fault;
      end else if (ack_done) begin
        valid_o <= 1'b1;
        waddr_o <= waddr_p1;
        hi_o    <= hi_p1;
        lo_o    <= lo_p1;
        whilo_o <= whilo_p1;
        if (is_load_op(op_p1)) begin
          result_o <= load_extend(op_p1, off_p1, mem_rdata_i);
          we_o     <= we_p1;
        end
      end else if (to_done) begin
        valid_o   <= 1'b1;
        waddr_o   <= waddr_p1;
        bus_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Parametrised successor to the combinational memory-access pass-through stage.
- Sits between EX and WB. Executes MIPS loads and stores on a req/ack data-memory bus, performs byte and halfword lane steering and sign or zero extension, and detects misaligned addresses.
- Stalls the pipeline while a bus transfer is outstanding and enforces a bus timeout.
- Register-file and HI/LO write-back fields pass through on registered outputs, so WB sees everything one cycle after completion.

Parameters:
- ADDR_W, 32, data-memory address width; ADDR_W <= 32, taken from result_i[ADDR_W-1:0].
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT, 255, maximum WAIT cycles without mem_ack_i before bus error; must be >= 1.
- Data path is fixed at 32 bits, big-endian byte lanes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  EX presents an instruction.
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 9 SB, 10 SH, 11 SW; other codes are treated as NONE.
- result_i  in  32  ALU result, or effective address for memory ops.
- store_data_i  in  32  store source (rt).
- waddr_i  in  REG_ADDR_W  destination register.
- we_i  in  1  register write enable.
- hi_i, lo_i  in  32 each  HI/LO write values.
- whilo_i  in  1  HI/LO write enable.
- stall_o  out  1  EX must hold all inputs stable while this is high.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits = 0).
- mem_sel_o  out  4  byte enables; bit3 = byte at address offset 0.
- mem_wdata_o  out  32  store data, replicated on lanes.
- mem_rdata_i  in  32  load data, valid when mem_ack_i is high.
- mem_ack_i  in  1  transfer complete.
- valid_o  out  1  WB fields valid this cycle.
- result_o  out  32  write-back data.
- waddr_o  out  REG_ADDR_W  write-back register.
- we_o  out  1  write-back register enable.
- hi_o, lo_o  out  32 each  HI/LO write values.
- whilo_o  out  1  HI/LO write enable.
- align_err_o  out  1  one-cycle pulse: misaligned access.
- bus_err_o  out  1  one-cycle pulse: bus timeout.

Behaviour:
- Reset (rst sampled high on a rising edge):
  - All outputs are 0 and the state returns to IDLE. This includes stall_o, which is combinational but forced to 0 by the IDLE state with no request pending.
  - Reset during WAIT abandons the transfer: mem_req_o is low from the following cycle and nothing is written back.
- States: IDLE, WAIT.
- Non-memory op, IDLE, valid_i=1:
  - stall_o=0.
  - Next edge: valid_o=1, and result/waddr/we/hi/lo/whilo are copied from the inputs.
  - Latency is 1 cycle; back-to-back issue sustains one instruction per cycle.
- No valid_i in IDLE: next cycle valid_o=0, we_o=0, whilo_o=0; the other data outputs hold their previous values.
- Alignment rules:
  - Halfword ops require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Byte ops are always aligned.
- Misaligned memory op in IDLE:
  - stall_o=0 and no request is issued.
  - Next edge: align_err_o=1, valid_o=1, we_o=0, whilo_o=0.
- Aligned memory op in IDLE:
  - stall_o=1 combinationally.
  - Next edge: latch op, address offset, waddr, we, hi/lo/whilo; drive mem_req_o=1 with addr/sel/we/wdata; clear the timeout counter; go to WAIT.
- Byte enables:
  - Byte ops: mem_sel_o = 1000 >> addr[1:0].
  - Halfword ops: mem_sel_o = 1100 >> addr[1:0].
  - Word ops: mem_sel_o = 1111.
- Store data:
  - SB: mem_wdata_o = {4{rt[7:0]}}.
  - SH: mem_wdata_o = {2{rt[15:0]}}.
  - SW: mem_wdata_o = rt.
- WAIT:
  - mem_req_o and all bus fields are held constant until the transfer ends.
  - stall_o = !mem_ack_i.
  - The counter increments on every cycle without ack.
- Ack in WAIT (mem_ack_i=1):
  - Next edge: mem_req_o=0, state returns to IDLE, valid_o=1, HI/LO fields are taken from the latch.
  - Loads: lane select per offset, LB/LH sign-extend, LBU/LHU zero-extend, result_o = extended data, we_o = latched we.
  - Stores: we_o=0.
  - Ack has priority over timeout when both would occur in the same cycle.
- Timeout: if the counter equals TIMEOUT-1 and mem_ack_i=0:
  - stall_o=0 in that cycle.
  - Next edge: mem_req_o=0, state returns to IDLE, bus_err_o=1, valid_o=1, we_o=0, whilo_o=0.
- mem_ack_i outside WAIT is ignored.
- Minimum memory-op latency: accept cycle + 1 WAIT cycle, with WB valid on the following edge.

Test Plan:
- Non-mem op stream:
  - Stimulus: three consecutive ops with result_i 0x11, 0x22, 0x33, waddr 1, 2, 3, we=1.
  - Required: valid_o on three consecutive cycles with matching data, one cycle after each input; stall_o never asserted.
- LB sign extension:
  - Stimulus: addr 0x1001, mem_rdata_i 0x12F45678, ack on the first WAIT cycle.
  - Required: mem_sel_o=0100, mem_addr_o=0x1000, result_o=0xFFFFFFF4, stall_o high exactly 1 cycle.
  - Repeat with LBU: result_o=0x000000F4.
- SH:
  - Stimulus: addr 0x2002, rt 0xAAAABEEF, ack delayed 3 cycles.
  - Required: mem_sel_o=0011, mem_wdata_o=0xBEEFBEEF, req held constant for 4 cycles, we_o=0 at completion.
- Misaligned LW:
  - Stimulus: LW at addr 0x3002.
  - Required: mem_req_o never rises, align_err_o=1 for one cycle, we_o=0, stall_o=0.
- Timeout:
  - Stimulus: TIMEOUT=4, LW with ack never asserted.
  - Required: req high for 4 cycles, then bus_err_o pulse, we_o=0, pipeline resumes.
- Reset mid-WAIT:
  - Stimulus: rst asserted on the 2nd WAIT cycle.
  - Required: next cycle mem_req_o=0, valid_o=0, stall_o=0, state IDLE; a late mem_ack_i is ignored.
